bit_count_unit: RTL
===================

# bit_count_unit

Parametrised, pipelined count unit for the execute stage, covering the Zbb count instructions CLZ, CTZ and CPOP on XLEN-bit operands. It generalises the single-cycle 32-bit trailing-zero counter in four ways: parametrised width, three operations, a two-stage registered pipeline with valid/ready backpressure, and a tag carried alongside each result. It sits beside the ALU and returns the result and tag to writeback.

## Interface
Parameters:
- XLEN, 32: operand width. Legal values are 32 and 64.
- TAG_W, 5: width of the opaque tag (destination register index) that travels with each operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts the operation this cycle.
- in_op  in  2  operation select, type bc_op_t: CLZ=0, CTZ=1, CPOP=2. Value 3 is reserved.
- in_x  in  XLEN  operand.
- in_tag  in  TAG_W  tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_res  out  XLEN  count, zero-extended to XLEN.
- out_tag  out  TAG_W  tag of the operation that produced out_res.

## Operation
- CTZ: number of zero bits below the lowest set bit. CTZ(0) = XLEN.
- CLZ: number of zero bits above the highest set bit. CLZ(0) = XLEN. Implemented as CTZ of the bit-reversed operand.
- CPOP: number of set bits, 0..XLEN.
- Reserved op (3): completes normally with out_res = 0.
- Counts are clog2(XLEN)+1 bits wide and zero-extended into out_res.
- Stage 1 (S1), registered:
  - Per 4-bit group: trailing-zero count (0..4), plus a zero-group flag.
  - Per 4-bit group: popcount (0..4).
  - Op and tag.
- Stage 2 (S2), registered: the reduction tree.
  - Trailing count: pairwise merge. If the lower half count equals its full width, the result is the upper count plus that width; otherwise it is the lower count.
  - Popcount: sum of all group popcounts.
  - The op selects which result goes to out_res.
- Handshake and pipeline control:
  - A transfer happens when valid and ready are both high on a rising edge.
  - out_valid is the S2 valid bit; out_res and out_tag are driven directly from S2 registers.
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational, no dependence on in_valid).
  - While stalled (out_valid=1, out_ready=0), S1 and S2 hold, and out_res/out_tag stay stable.
- Boundary conditions:
  - Simultaneous output drain and input accept in one cycle: full throughput, no bubble.
  - Both stages full and out_ready=0: in_ready=0.
  - in_x, in_op and in_tag are ignored when no input transfer occurs.

## Timing
- Latency is 2 cycles. An operation accepted at edge N gives out_valid=1 after edge N+1 and is visible through the cycle before edge N+2.
- Throughput is 1 operation per cycle when out_ready is held high.
- Capacity is 2 operations in flight.
- Reset (reset_n=0), applied asynchronously:
  - s1_valid and s2_valid clear, so out_valid=0.
  - out_res and out_tag are 0; all S1 data registers are 0.
  - in_ready=1 while in reset and after release.
- Reset asserted mid-operation discards all in-flight operations. No output transfer happens on the edge where reset_n is low.
- There is no combinational path from in_* to out_*.

## Structure
- Package bit_count_pkg holds:
  - typedef enum logic [1:0] bc_op_t {CLZ, CTZ, CPOP, BC_RSVD}
  - function clog2-based width helper CNT_W(xlen) = $clog2(xlen)+1
- Sub-module bc_reduce, purely combinational:
  - Parameter NGROUPS.
  - Takes the per-group trailing counts, zero flags and popcounts.
  - Returns the CNT_W trailing count and popcount.
  - Instantiated once, in the S1→S2 path.
- The top level holds the input mux and bit-reverse, the group encoders, both stage registers and the handshake logic.

## Test plan
- Zero operand, XLEN=32:
  - CTZ(0x00000000) → 32
  - CLZ(0x00000000) → 32
  - CPOP(0x00000000) → 0
  - CPOP(0xFFFFFFFF) → 32
  - out_valid exactly 2 cycles after the input transfer.
- Values, XLEN=32:
  - CTZ(0x80000000) → 31
  - CLZ(0x00010000) → 15
  - CPOP(0xF0F00001) → 9
  - CTZ(0x00000003) → 0
  - Tags 1..4 return in order.
- XLEN=64:
  - CLZ(0x0000000100000000) → 31
  - CTZ(0x0000000100000000) → 32
  - CTZ(0) → 64
  - CPOP(0x8000000000000001) → 2
- Backpressure:
  - Issue 4 back-to-back ops with out_ready=0. Only 2 are accepted, and in_ready=0 after the second.
  - out_res stays stable while stalled.
  - Raising out_ready drains the results in order with no loss or duplication.
  - Random in_valid/out_ready over 10k ops matches a reference model.
- Reset mid-flight:
  - With 2 ops in flight, pulse reset_n low for half a cycle.
  - out_valid, out_res and out_tag go to 0 immediately; in_ready=1.
  - The next op produces the correct result 2 cycles after acceptance.
- Reserved op:
  - in_op=3 with x=0xFFFFFFFF → out_res=0, tag preserved.

Source files
------------

// File: rtl/bit_count_pkg.sv
// Shared types and width helper for the Zbb count unit (CLZ / CTZ / CPOP).
package bit_count_pkg;

    typedef enum logic [1:0] {
        CLZ     = 2'd0,
        CTZ     = 2'd1,
        CPOP    = 2'd2,
        BC_RSVD = 2'd3
    } bc_op_t;

    // Count results need one extra bit so that a count equal to XLEN fits.
    function automatic int CNT_W(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/bc_reduce.sv
// Reduction tree: merges per-nibble trailing-zero counts and sums per-nibble popcounts.
module bc_reduce
    import bit_count_pkg::*;
#(
    parameter  int NGROUPS = 8,
    localparam int CW      = CNT_W(NGROUPS * 4)
)(
    input  logic [NGROUPS-1:0][2:0] grp_tz,
    input  logic [NGROUPS-1:0]      grp_zero,
    input  logic [NGROUPS-1:0][2:0] grp_pop,
    output logic [CW-1:0]           tz_cnt,
    output logic [CW-1:0]           pop_cnt
);

    localparam int LVLS = $clog2(NGROUPS);

    logic [CW-1:0] t_lvl [LVLS+1][NGROUPS];
    logic          f_lvl [LVLS+1][NGROUPS];

    // Level l node i covers 4<<l bits. A fully-zero lower half passes the
    // count through to the upper half, offset by the lower half's width.
    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            for (int i = 0; i < NGROUPS; i++) begin
                t_lvl[l][i] = '0;
                f_lvl[l][i] = 1'b0;
            end
        end
        for (int i = 0; i < NGROUPS; i++) begin
            t_lvl[0][i] = CW'(grp_tz[i]);
            f_lvl[0][i] = grp_zero[i];
        end
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < (NGROUPS >> (l + 1)); i++) begin
                f_lvl[l+1][i] = f_lvl[l][2*i] & f_lvl[l][2*i+1];
                t_lvl[l+1][i] = f_lvl[l][2*i] ? t_lvl[l][2*i+1] + CW'(4 << l)
                                              : t_lvl[l][2*i];
            end
        end
    end

    assign tz_cnt = t_lvl[LVLS][0];

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NGROUPS; i++) begin
            pop_cnt = pop_cnt + CW'(grp_pop[i]);
        end
    end

endmodule

// File: rtl/bit_count_unit.sv
// Two-stage pipelined CLZ/CTZ/CPOP unit with valid/ready handshake and tag passthrough.
module bit_count_unit
    import bit_count_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_res,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NG = XLEN / 4;
    localparam int CW = CNT_W(XLEN);

    bc_op_t            op_in;
    logic [XLEN-1:0]   x_rev;
    logic [XLEN-1:0]   x_sel;
    logic [NG-1:0][2:0] g_tz;
    logic [NG-1:0][2:0] g_pop;
    logic [NG-1:0]     g_zero;

    logic               s1_valid;
    bc_op_t             s1_op;
    logic [TAG_W-1:0]   s1_tag;
    logic [NG-1:0][2:0] s1_tz;
    logic [NG-1:0][2:0] s1_pop;
    logic [NG-1:0]      s1_zero;

    logic               s2_valid;
    logic [CW-1:0]      s2_cnt;
    logic [TAG_W-1:0]   s2_tag;

    logic               s1_adv;
    logic               s2_adv;
    logic [CW-1:0]      red_tz;
    logic [CW-1:0]      red_pop;
    logic [CW-1:0]      s2_cnt_d;

    assign op_in = bc_op_t'(in_op);

    // CLZ reuses the trailing-zero path on the mirrored operand.
    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            x_rev[i] = in_x[XLEN-1-i];
        end
    end

    assign x_sel = (op_in == CLZ) ? x_rev : in_x;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [3:0] nib;
        logic [2:0] tz;

        assign nib = x_sel[4*g +: 4];

        always_comb begin
            tz = 3'd4;
            for (int b = 3; b >= 0; b--) begin
                if (nib[b]) tz = 3'(b);
            end
        end

        assign g_tz[g]   = tz;
        assign g_zero[g] = (nib == 4'd0);
        assign g_pop[g]  = 3'(nib[0]) + 3'(nib[1]) + 3'(nib[2]) + 3'(nib[3]);
    end

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= CLZ;
            s1_tag   <= '0;
            s1_tz    <= '0;
            s1_pop   <= '0;
            s1_zero  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= op_in;
                s1_tag  <= in_tag;
                s1_tz   <= g_tz;
                s1_pop  <= g_pop;
                s1_zero <= g_zero;
            end
        end
    end

    bc_reduce #(.NGROUPS(NG)) u_reduce (
        .grp_tz   (s1_tz),
        .grp_zero (s1_zero),
        .grp_pop  (s1_pop),
        .tz_cnt   (red_tz),
        .pop_cnt  (red_pop)
    );

    always_comb begin
        case (s1_op)
            CLZ, CTZ: s2_cnt_d = red_tz;
            CPOP:     s2_cnt_d = red_pop;
            default:  s2_cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_cnt   <= '0;
            s2_tag   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_cnt <= s2_cnt_d;
                s2_tag <= s1_tag;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_res   = {{(XLEN-CW){1'b0}}, s2_cnt};
    assign out_tag   = s2_tag;

endmodule
